// File: rtl/pdm_decimator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_decimator
// Purpose  : Drives an external PDM source clock, samples its data line and
//            decimates it with a 3rd-order CIC into 16-bit unsigned PCM with a
//            one-cycle start strobe. Define PDM_STEREO_EN for a right channel
//            sampled on the falling pdm_clk phase (adds soundOutR).
// Revision : 1.0 - initial release
// ============================================================================

module pdm_cic_channel #(
    parameter int LOG2_DECIM = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        sample_i,
    input  logic        x_i,
    input  logic        dump_i,
    output logic [15:0] pcm_o
);
    localparam int W     = 3 * LOG2_DECIM + 1;
    localparam int SHIFT = 3 * LOG2_DECIM - 16;

    logic [W-1:0] int1_q, int2_q, int3_q;
    logic [W-1:0] int1_d, int2_d, int3_d;
    logic [W-1:0] dly1_q, dly2_q, dly3_q;
    logic [W-1:0] int3_now, comb1, comb2, comb_y;
    logic [16:0]  scaled;

    always_comb begin
        int1_d   = int1_q + W'(x_i);
        int2_d   = int2_q + int1_d;
        int3_d   = int3_q + int2_d;
        // A sample and a dump may share a cycle; the dump must include it.
        int3_now = sample_i ? int3_d : int3_q;
        comb1    = int3_now - dly1_q;
        comb2    = comb1 - dly2_q;
        comb_y   = comb2 - dly3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int1_q <= '0;
            int2_q <= '0;
            int3_q <= '0;
            dly1_q <= '0;
            dly2_q <= '0;
            dly3_q <= '0;
        end else if (clear_i) begin
            int1_q <= '0;
            int2_q <= '0;
            int3_q <= '0;
            dly1_q <= '0;
            dly2_q <= '0;
            dly3_q <= '0;
        end else begin
            if (sample_i) begin
                int1_q <= int1_d;
                int2_q <= int2_d;
                int3_q <= int3_d;
            end
            if (dump_i) begin
                dly1_q <= int3_now;
                dly2_q <= comb1;
                dly3_q <= comb2;
            end
        end
    end

    // The scaled value is always 17 bits wide so bit 16 flags full scale.
    generate
        if (SHIFT >= 0) begin : g_shift_right
            assign scaled = 17'(comb_y >> SHIFT);
        end else begin : g_shift_left
            assign scaled = {comb_y, 1'b0};
        end
    endgenerate

    assign pcm_o = scaled[16] ? 16'hFFFF : scaled[15:0];

endmodule

module pdm_decimator #(
    parameter int CLK_DIV    = 25,
    parameter int LOG2_DECIM = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pdm_data,
    output logic        pdm_clk,
    output logic [15:0] soundOut,
`ifdef PDM_STEREO_EN
    output logic [15:0] soundOutR,
`endif
    output logic        startO,
    output logic        busy
);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  s1_q, s2_q;
    logic [DIV_W-1:0]      div_q;
    logic                  pdm_clk_q;
    logic [LOG2_DECIM-1:0] dec_q;
    logic [1:0]            warm_q;
    logic [15:0]           sound_q;
    logic                  start_q;
    logic                  running, div_wrap, rise_tick, decim_tick, emit;
    logic [15:0]           pcm_l;

    assign running    = enable && (state_q != ST_IDLE);
    assign div_wrap   = running && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_tick  = div_wrap && !pdm_clk_q;
    assign decim_tick = rise_tick && (dec_q == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (decim_tick && warm_q == 2'd3) begin
                    state_d = ST_RUN;
                    emit    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    emit = decim_tick;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            dec_q     <= '0;
            warm_q    <= 2'd0;
            sound_q   <= 16'h0000;
            start_q   <= 1'b0;
        end else begin
            s1_q    <= pdm_data;
            s2_q    <= s1_q;
            start_q <= emit;
            if (emit) begin
                sound_q <= pcm_l;
            end
            if (!running) begin
                div_q     <= '0;
                pdm_clk_q <= 1'b0;
                dec_q     <= '0;
                warm_q    <= 2'd0;
            end else begin
                if (div_wrap) begin
                    div_q     <= '0;
                    pdm_clk_q <= ~pdm_clk_q;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
                if (rise_tick) begin
                    dec_q <= dec_q + LOG2_DECIM'(1);
                end
                // Counts the discarded warm-up ticks, saturating at three.
                if (decim_tick && warm_q != 2'd3) begin
                    warm_q <= warm_q + 2'd1;
                end
            end
        end
    end

    pdm_cic_channel #(
        .LOG2_DECIM (LOG2_DECIM)
    ) u_cic_left (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!running),
        .sample_i (rise_tick),
        .x_i      (s2_q),
        .dump_i   (decim_tick),
        .pcm_o    (pcm_l)
    );

`ifdef PDM_STEREO_EN
    logic        fall_tick;
    logic [15:0] pcm_r;
    logic [15:0] sound_r_q;

    assign fall_tick = div_wrap && pdm_clk_q;

    // Right channel dumps on the left decim tick so both samples stay paired.
    pdm_cic_channel #(
        .LOG2_DECIM (LOG2_DECIM)
    ) u_cic_right (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!running),
        .sample_i (fall_tick),
        .x_i      (s2_q),
        .dump_i   (decim_tick),
        .pcm_o    (pcm_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sound_r_q <= 16'h0000;
        end else if (emit) begin
            sound_r_q <= pcm_r;
        end
    end

    assign soundOutR = sound_r_q;
`endif

    assign pdm_clk  = pdm_clk_q;
    assign soundOut = sound_q;
    assign startO   = start_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pdm_decimator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pdm_decimator
// Purpose  : Scoreboard bench for pdm_decimator against a convolution model
//            of the 3rd-order CIC impulse response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_decimator;
    localparam int CLK_DIV    = 25;
    localparam int LOG2_DECIM = 6;
    localparam int D          = 1 << LOG2_DECIM;
    localparam int KLEN       = 3 * D - 2;
    localparam int PERIOD     = 2 * CLK_DIV * D;
    localparam int SH         = 3 * LOG2_DECIM - 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pdm_data = 1'b1;
    wire         pdm_clk;
    wire  [15:0] soundOut;
    wire         startO;
    wire         busy;
`ifdef PDM_STEREO_EN
    wire  [15:0] soundOutR;
`endif

    pdm_decimator #(
        .CLK_DIV    (CLK_DIV),
        .LOG2_DECIM (LOG2_DECIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pdm_data  (pdm_data),
        .pdm_clk   (pdm_clk),
        .soundOut  (soundOut),
`ifdef PDM_STEREO_EN
        .soundOutR (soundOutR),
`endif
        .startO    (startO),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Impulse response of (1 + z^-1 + ... + z^-(D-1))^3.
    int h[KLEN];
    initial begin
        for (int j = 0; j < KLEN; j++) h[j] = 0;
        for (int a = 0; a < D; a++)
            for (int b = 0; b < D; b++)
                for (int c = 0; c < D; c++)
                    h[a + b + c] = h[a + b + c] + 1;
    end

    // PDM source: new bit on each falling pdm_clk edge.
    int mode = 1;
    int bitcnt = 0;
    always @(negedge pdm_clk) begin
        bitcnt++;
        case (mode)
            0: pdm_data = 1'b0;
            1: pdm_data = 1'b1;
            2: pdm_data = (bitcnt % 2) == 0;
            3: pdm_data = (bitcnt % 4) != 3;
            default: pdm_data = 1'($urandom % 2);
        endcase
    end

    // Reference model: every D-th sampled bit yields a convolution output.
    bit          samp[$];
    logic [15:0] expq[$];
    always @(posedge pdm_clk) begin
        int     n;
        longint y;
        longint r;
        samp.push_back(pdm_data);
        n = samp.size() - 1;
        if ((n % D) == D - 1 && (n / D) >= 3) begin
            y = 0;
            for (int j = 0; j < KLEN; j++)
                if (n - j >= 0) y += longint'(h[j]) * longint'(samp[n - j]);
            r = y >> SH;
            expq.push_back(r >= 65536 ? 16'hFFFF : 16'(r));
        end
    end

    // Monitor: pops one expectation per strobe.
    logic [15:0] last_exp = 16'h0000;
    logic        prev_start = 1'b0;
    int          strobes = 0;
    always @(negedge clk) begin
        if (startO === 1'b1) begin
            strobes++;
            check("strobe_not_back_to_back", 32'(prev_start), 32'd0);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got soundOut=0x%0h expected no strobe", soundOut);
            end else begin
                last_exp = expq.pop_front();
                check("sample_value", 32'(soundOut), 32'(last_exp));
            end
        end
        prev_start = startO;
    end

    task automatic wait_strobe(input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit && waited < 0; i++) begin
            @(negedge clk);
            if (startO === 1'b1) waited = i;
        end
        if (waited < 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: got none expected within %0d cycles", limit);
        end
    endtask

    initial begin
        #1_100_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s0;
        repeat (3) @(negedge clk);
        check("reset_pdm_clk", 32'(pdm_clk), 32'd0);
        check("reset_soundOut", 32'(soundOut), 32'd0);
        check("reset_startO", 32'(startO), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pdm_clk", 32'(pdm_clk), 32'd0);

        // Constant 1: warm-up latency, full scale, exact strobe period.
        mode = 1;
        enable = 1'b1;
        wait_strobe(14000, w);
        check_range("first_latency", w, 12700, 12900);
        check("const1_value", 32'(soundOut), 32'hFFFF);
        check("run_busy", 32'(busy), 32'd1);
        wait_strobe(PERIOD + 10, w);
        check("strobe_period", 32'(w), 32'(PERIOD));

        mode = 0;
        for (int k = 0; k < 3; k++) wait_strobe(PERIOD + 10, w);
        check("const0_value", 32'(soundOut), 32'h0000);
        check("const0_busy", 32'(busy), 32'd1);

        mode = 2;
        for (int k = 0; k < 3; k++) wait_strobe(PERIOD + 10, w);
        check("toggle_value", 32'(soundOut), 32'h8000);

        mode = 3;
        for (int k = 0; k < 3; k++) wait_strobe(PERIOD + 10, w);
        check("pattern1110_value", 32'(soundOut), 32'hC000);
        check("strobe_period_late", 32'(w), 32'(PERIOD));

        mode = 4;
        for (int k = 0; k < 2; k++) wait_strobe(PERIOD + 10, w);

        // Enable dropped mid-run.
        repeat (100) @(negedge clk);
        enable = 1'b0;
        s0 = strobes;
        @(negedge clk);
        samp.delete();
        check("drop_pdm_clk", 32'(pdm_clk), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        repeat (2000) @(negedge clk);
        check("drop_hold", 32'(soundOut), 32'(last_exp));
        check("drop_no_strobe", 32'(strobes - s0), 32'd0);
        check("drop_pdm_clk_idle", 32'(pdm_clk), 32'd0);

        // Re-enable: warm-up must be repeated.
        mode = 1;
        enable = 1'b1;
        wait_strobe(14000, w);
        check_range("reenable_latency", w, 12700, 12900);

        // Asynchronous reset mid-run with data high.
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_soundOut", 32'(soundOut), 32'd0);
        check("rst_startO", 32'(startO), 32'd0);
        check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        samp.delete();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        wait_strobe(14000, w);
        check_range("post_rst_latency", w, 12700, 12900);
        check("post_rst_value", 32'(soundOut), 32'hFFFF);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
